// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, valid/ready on both sides.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  // Handshakes: a transfer happens on any rising edge where valid & ready are both high;
  // valid never depends on ready, and result is held while out_valid & ~out_ready.

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        op_sel;
  logic              neg_q;
  logic              neg_r;
  logic              short_op;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  assign a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
  assign b_signed = a_signed && (funct3 != 3'b010);
  assign sa       = a_signed & a[XLEN-1];
  assign sb       = b_signed & b[XLEN-1];
  assign mag_a    = sa ? -a : a;
  assign mag_b    = sb ? -b : b;

  assign div_zero    = funct3[2] & (b == '0);
  assign div_ovf     = funct3[2] & ~funct3[0] & (a == MIN_NEG) & (b == '1);
  assign special_res = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod, fast_signed;
  logic [XLEN-1:0]   fast_res;

  assign fast_prod   = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fast_signed = (sa ^ sb) ? -fast_prod : fast_prod;
  assign fast_res    = (funct3[1:0] == 2'b00) ? fast_signed[XLEN-1:0] : fast_signed[2*XLEN-1:XLEN];
`endif

  // acc = {partial product hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next  = {mul_sum, acc[XLEN-1:1]};
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign acc_next  = (state == MUL) ? mul_next : div_next;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res;

  assign prod    = neg_q ? -mul_next : mul_next;
  assign mul_res = (op_sel == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign quo     = div_next[XLEN-1:0];
  assign rem     = div_next[2*XLEN-1:XLEN];
  assign div_res = op_sel[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);

  // Pre-resolved results spend one cycle in MUL/DIV with the counter at its last value,
  // so every result leaves through the same registered path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_sel    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      short_op  <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_sel <= funct3[1:0];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            state  <= funct3[2] ? DIV : MUL;
            if (div_zero | div_ovf) begin
              short_op <= 1'b1;
              cnt      <= LAST;
              acc      <= {{XLEN{1'b0}}, special_res};
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!funct3[2]) begin
              short_op <= 1'b1;
              cnt      <= LAST;
              acc      <= {{XLEN{1'b0}}, fast_res};
            end
`endif
            else begin
              short_op <= 1'b0;
              cnt      <= '0;
              opnd     <= funct3[2] ? mag_b : mag_a;
              acc      <= {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
            end
          end
        end
        MUL, DIV: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            if (short_op)
              result <= acc[XLEN-1:0];
            else
              result <= (state == MUL) ? mul_res : div_res;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32): vector table, random ops against a reference model,
// plus backpressure, flush and mid-operation reset sequences.
module tb_muldiv_unit;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [XLEN-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xs, xu, ys, yu, p;
    logic signed [31:0] sx, sy, sr;
    logic ovf;
    xs  = {{32{x[31]}}, x};
    xu  = {32'h0, x};
    ys  = {{32{y[31]}}, y};
    yu  = {32'h0, y};
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    ref_model = '0;
    case (f3)
      3'd0: begin p = xu * yu; ref_model = p[31:0];  end
      3'd1: begin p = xs * ys; ref_model = p[63:32]; end
      3'd2: begin p = xs * yu; ref_model = p[63:32]; end
      3'd3: begin p = xu * yu; ref_model = p[63:32]; end
      3'd4: begin
        if (y == 0) ref_model = 32'hFFFF_FFFF;
        else if (ovf) ref_model = x;
        else begin sr = sx / sy; ref_model = sr; end
      end
      3'd5: ref_model = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) ref_model = x;
        else if (ovf) ref_model = 32'h0;
        else begin sr = sx % sy; ref_model = sr; end
      end
      default: ref_model = (y == 0) ? x : x % y;
    endcase
  endfunction

  // Drive one op with out_ready high, wait (bounded) for the result, compare against the scoreboard.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp, input int exp_lat, input string name);
    int lat;
    logic [31:0] e;
    @(negedge clk);
    check({name, " in_ready"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    funct3    = f3;
    a         = av;
    b         = bv;
    out_ready = 1'b1;
    exp_q.push_back(exp);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
    end while (!out_valid && lat < 100);
    e = exp_q.pop_front();
    check({name, " out_valid"}, out_valid, 1'b1);
    check({name, " result"}, result, e);
    check({name, " latency"}, lat, exp_lat);
    @(posedge clk);
  endtask

  task automatic watch_no_output(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check({name, " no out_valid"}, seen, 1'b0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] av, bv, e;
    int lat, wait_cnt;

    vecs[0]  = '{3'd4, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33};
    vecs[1]  = '{3'd6, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33};
    vecs[2]  = '{3'd5, 32'h5,         32'h0,         32'hFFFF_FFFF, 2};
    vecs[3]  = '{3'd7, 32'h5,         32'h0,         32'h5,         2};
    vecs[4]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[5]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2};
    vecs[6]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
    vecs[7]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
    vecs[8]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[9]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT};
    vecs[10] = '{3'd4, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[11] = '{3'd6, 32'h7,         32'hFFFF_FFFE, 32'h1,         33};
    vecs[12] = '{3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33};
    vecs[13] = '{3'd1, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, MUL_LAT};
    vecs[14] = '{3'd5, 32'hFFFF_FFFF, 32'h3,         32'h5555_5555, 33};
    vecs[15] = '{3'd7, 32'd10,        32'd3,         32'd1,         33};
    vecs[16] = '{3'd4, 32'h1234,      32'h0,         32'hFFFF_FFFF, 2};
    vecs[17] = '{3'd6, 32'h1234,      32'h0,         32'h1234,      2};

    rst_n = 1'b0; in_valid = 1'b0; funct3 = '0; a = '0; b = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset result", result, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++)
      run_op(vecs[i].f3, vecs[i].av, vecs[i].bv, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      av = $urandom;
      case ($urandom_range(0, 4))
        0: bv = 32'h0;
        1: bv = $urandom_range(1, 20);
        2: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
        default: bv = $urandom;
      endcase
      if (!f3[2]) lat = MUL_LAT;
      else if (bv == 0 || (!f3[0] && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF)) lat = 2;
      else lat = 33;
      run_op(f3, av, bv, ref_model(f3, av, bv), lat, $sformatf("rnd%0d f3=%0d", i, f3));
    end

    // backpressure: result must hold while out_ready stays low
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'd4; a = 32'd100; b = 32'd7; out_ready = 1'b0;
    exp_q.push_back(32'd14);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("bp out_valid", out_valid, 1'b1);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d result", i), result, e);
      check($sformatf("bp hold%0d in_ready", i), in_ready, 1'b0);
      check($sformatf("bp hold%0d busy", i), busy, 1'b1);
      check($sformatf("bp hold%0d out_valid", i), out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release in_ready", in_ready, 1'b1);
    check("bp release busy", busy, 1'b0);
    check("bp release out_valid", out_valid, 1'b0);

    // flush landing on DIV iteration 10
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'd4; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("flush mid-div busy before", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush in_ready", in_ready, 1'b1);
    check("flush busy", busy, 1'b0);
    check("flush out_valid", out_valid, 1'b0);
    watch_no_output("flush div", 40);

    // flush and in_valid together in IDLE: nothing accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; funct3 = 3'd5; a = 32'd9; b = 32'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush+valid busy", busy, 1'b0);
    check("flush+valid in_ready", in_ready, 1'b1);
    watch_no_output("flush+valid", 40);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'd0; a = 32'd123; b = 32'd456; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", busy, 1'b0);
    check("async rst out_valid", out_valid, 1'b0);
    check("async rst result", result, 32'h0);
    check("async rst in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd7, 32'd6, 32'd42, MUL_LAT, "post-rst mul");
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, "post-rst rem");

    check("scoreboard empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
